// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
// Imported by seq_alu and its iterative multiply/divide datapath.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_LSH  = 4'b0110;
    localparam logic [3:0] OP_ASH  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ITER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } flags_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
// hi/lo hold the running {product} or {remainder, quotient} pair.
module iter_muldiv
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  is_div,
    output logic                  div_zero,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] operand_q;
    logic [CW-1:0]         count_q;
    logic                  div_q;
    logic [DATA_WIDTH:0]   add_sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   sub_diff;

    always_comb begin
        add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, operand_q} : '0);
        shifted  = {hi, lo[DATA_WIDTH-1]};
        // A borrow out of the top bit means the trial subtraction failed.
        sub_diff = shifted - {1'b0, operand_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            operand_q <= '0;
            count_q   <= '0;
            div_q     <= 1'b0;
            lo        <= '0;
            hi        <= '0;
        end else if (load) begin
            operand_q <= b;
            count_q   <= '0;
            div_q     <= (op == OP_DIVU);
            lo        <= a;
            hi        <= '0;
        end else if (step && !div_zero) begin
            count_q <= count_q + CW'(1);
            if (div_q) begin
                if (!sub_diff[DATA_WIDTH]) begin
                    hi <= sub_diff[DATA_WIDTH-1:0];
                    lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shifted[DATA_WIDTH-1:0];
                    lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi, lo} <= {add_sum, lo[DATA_WIDTH-1:1]};
            end
        end
    end

    assign is_div   = div_q;
    assign div_zero = div_q && (operand_q == '0);
    assign last     = (count_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU.
// Handshake: start is taken only when busy=0; done pulses once when results change.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            select,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] out_hi,
    output logic                  C,
    output logic                  L,
    output logic                  F,
    output logic                  Z,
    output logic                  N,
    output logic [1:0]            state_dbg
);

    localparam int SW  = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    state_t state_q, state_d;
    flags_t flags_q, single_flags, fin_flags;

    logic                  accept_single, accept_iter;
    logic                  md_is_div, md_div_zero, md_last;
    logic [DATA_WIDTH-1:0] md_lo, md_hi;
    logic [DATA_WIDTH-1:0] single_out, fin_out, fin_hi;
    logic [DATA_WIDTH:0]   sum_ext, diff_ext;
    logic [SW-1:0]         sh_amt;

    assign accept_single = (state_q == ST_IDLE) && start && !is_iter_op(select);
    assign accept_iter   = (state_q == ST_IDLE) && start &&  is_iter_op(select);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_iter) state_d = ST_ITER;
            ST_ITER:   if (md_div_zero || md_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        state_dbg = state_q;
    end

    iter_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept_iter),
        .step     (state_q == ST_ITER),
        .op       (select),
        .a        (a),
        .b        (b),
        .is_div   (md_is_div),
        .div_zero (md_div_zero),
        .last     (md_last),
        .lo       (md_lo),
        .hi       (md_hi)
    );

    // Shift magnitude uses only the low bits of |b|, so negate just those bits.
    always_comb begin
        sum_ext      = {1'b0, a} + {1'b0, b};
        diff_ext     = {1'b0, a} - {1'b0, b};
        sh_amt       = b[MSB] ? (~b[SW-1:0] + SW'(1)) : b[SW-1:0];
        single_out   = '0;
        single_flags = '0;
        case (select)
            OP_ADD: begin
                single_out     = sum_ext[MSB:0];
                single_flags.c = sum_ext[DATA_WIDTH];
                single_flags.f = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                single_out     = diff_ext[MSB:0];
                single_flags.c = diff_ext[DATA_WIDTH];
                single_flags.l = diff_ext[DATA_WIDTH];
                single_flags.f = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
                single_flags.n = ($signed(a) < $signed(b));
            end
            OP_AND:  single_out = a & b;
            OP_OR:   single_out = a | b;
            OP_XOR:  single_out = a ^ b;
            OP_NOT:  single_out = ~a;
            OP_LSH:  single_out = b[MSB] ? (a >> sh_amt) : (a << sh_amt);
            OP_ASH:  single_out = b[MSB] ? $unsigned($signed(a) >>> sh_amt) : (a << sh_amt);
            default: single_out = '0;
        endcase
        single_flags.z = (single_out == '0);
    end

    always_comb begin
        fin_out     = md_div_zero ? '1 : md_lo;
        fin_hi      = md_div_zero ? md_lo : md_hi;
        fin_flags   = '0;
        fin_flags.f = md_is_div ? md_div_zero : (md_hi != '0);
        fin_flags.z = (fin_out == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done    <= 1'b0;
            out     <= '0;
            out_hi  <= '0;
            flags_q <= '0;
        end else begin
            done <= 1'b0;
            if (accept_single) begin
                done    <= 1'b1;
                out     <= single_out;
                out_hi  <= '0;
                flags_q <= single_flags;
            end else if (state_q == ST_FINISH) begin
                done    <= 1'b1;
                out     <= fin_out;
                out_hi  <= fin_hi;
                flags_q <= fin_flags;
            end
        end
    end

    assign C = flags_q.c;
    assign L = flags_q.l;
    assign F = flags_q.f;
    assign Z = flags_q.z;
    assign N = flags_q.n;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model + latency-count scoreboard checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_seq_alu;

    localparam int DW = 16;
    localparam int W  = 2 * DW + 5;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start  = 1'b0;
    logic [DW-1:0] a      = '0;
    logic [DW-1:0] b      = '0;
    logic [3:0]    select = '0;
    logic          busy, done;
    logic [DW-1:0] out, out_hi;
    logic          C, L, F, Z, N;
    logic [1:0]    state_dbg;

    seq_alu #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .select    (select),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .out_hi    (out_hi),
        .C         (C),
        .L         (L),
        .F         (F),
        .Z         (Z),
        .N         (N),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference model: {out_hi, out, C, L, F, Z, N}
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [DW-1:0] aa,
                                           input logic [DW-1:0] bb);
        longint ua = longint'(aa);
        longint ub = longint'(bb);
        longint sa = longint'($signed(aa));
        longint sb = longint'($signed(bb));
        longint r  = 0;
        longint rh = 0;
        logic c = 0, l = 0, f = 0, n = 0;
        int sh;
        sh = int'(((sb < 0) ? -sb : sb) % DW);
        case (op)
            4'd0: begin r = ua + ub; c = (r > 65535); f = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1: begin r = ua - ub; c = (ua < ub); l = c; n = (sa < sb);
                        f = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~ua;
            4'd6: r = (sb >= 0) ? (ua << sh) : (ua >> sh);
            4'd7: r = (sb >= 0) ? (ua << sh) : (sa >>> sh);
            4'd8: begin r = ua * ub; rh = r >> 16; f = (rh != 0); end
            4'd9: begin
                if (ub == 0) begin r = 65535; rh = ua; f = 1; end
                else begin r = ua / ub; rh = ua % ub; end
            end
            default: r = 0;
        endcase
        r  = r & 'hFFFF;
        rh = rh & 'hFFFF;
        return {rh[15:0], r[15:0], c, l, f, (r == 0), n};
    endfunction

    // scoreboard: expected results queued on acceptance, released after the op's latency
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp = '0;
    logic         exp_done = 1'b0;
    int           wait_left = 0;
    int           edge_cnt = 0;
    bit           model_live = 0;

    always @(posedge clk) begin
        edge_cnt++;
        model_live = 1;
        if (!reset_n) begin
            exp_q.delete();
            cur_exp   = '0;
            wait_left = 0;
            exp_done  = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) begin
                    exp_done = 1'b1;
                    cur_exp  = exp_q.pop_front();
                end
            end else if (start) begin
                exp_q.push_back(model(select, a, b));
                if (select == 4'd8 || select == 4'd9) begin
                    wait_left = (select == 4'd9 && b == '0) ? 2 : DW + 1;
                end else begin
                    exp_done = 1'b1;
                    cur_exp  = exp_q.pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("done", W'(done), W'(exp_done));
            check("busy", W'(busy), W'(wait_left > 0));
            check("result", {out_hi, out, C, L, F, Z, N}, cur_exp);
        end
    end

    // driver tasks (called at a negedge)
    int acc_edge = 0;

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] aa, input logic [DW-1:0] bb);
        select = op;
        a      = aa;
        b      = bb;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        acc_edge = edge_cnt;
    endtask

    task automatic wait_done(output int lat);
        int guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done within %0d cycles", guard);
        end
        lat = edge_cnt - acc_edge;
    endtask

    logic [3:0]    t_op[12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd6, 4'd0, 4'd1, 4'd1, 4'd15};
    logic [DW-1:0] t_a[12]  = '{16'hFF00, 16'hF000, 16'hAAAA, 16'h0000, 16'h0001, 16'h8000,
                                16'h8000, 16'h1234, 16'hFFFF, 16'h8000, 16'h0005, 16'h1234};
    logic [DW-1:0] t_b[12]  = '{16'h0F0F, 16'h000F, 16'hAAAA, 16'h1234, 16'h000F, 16'hFFF1,
                                16'hFFF1, 16'h8000, 16'h0001, 16'h0001, 16'h0005, 16'h5678};

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_hi, out, C, L, F, Z, N}, '0);
        check("reset_busy_done", W'({busy, done}), '0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(4'd0, 16'h7FFF, 16'h0001);
        wait_done(lat);
        check("add_latency", W'(lat), W'(0));
        check("add_ovf", {out, C, F, Z}, {16'h8000, 1'b0, 1'b1, 1'b0});

        issue(4'd1, 16'h0003, 16'h0005);
        check("sub_borrow", {out, C, L, N, F}, {16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0});
        issue(4'd7, 16'h8000, 16'hFFFC);
        check("ash_right", W'(out), W'(16'hF800));

        for (int i = 0; i < 12; i++) issue(t_op[i], t_a[i], t_b[i]);
        check("reserved_op", {out_hi, out, Z}, {32'h0, 1'b1});
        @(negedge clk);

        issue(4'd8, 16'h1234, 16'h0100);
        wait_done(lat);
        check("mul_latency", W'(lat), W'(DW + 1));
        check("mul_result", {out_hi, out, F}, {16'h0012, 16'h3400, 1'b1});

        issue(4'd9, 16'd100, 16'd7);
        wait_done(lat);
        check("divu_result", {out, out_hi, F}, {16'd14, 16'd2, 1'b0});
        issue(4'd9, 16'd5, 16'd0);
        wait_done(lat);
        check("div0_latency", W'(lat), W'(2));
        check("div0_result", {out, out_hi, F}, {16'hFFFF, 16'd5, 1'b1});

        issue(4'd8, 16'h00FF, 16'h0101);
        repeat (4) @(negedge clk);
        select = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("mul_ignore_start", {out_hi, out, F}, {16'h0000, 16'hFFFF, 1'b0});
        issue(4'd9, 16'd1000, 16'd3);
        wait_done(lat);
        check("b2b_latency", W'(lat), W'(DW + 1));
        check("b2b_divu", {out, out_hi}, {16'd333, 16'd1});

        issue(4'd8, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        select = 4'd0; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_outputs", {out_hi, out, C, L, F, Z, N, busy, done}, '0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(4'd0, 16'd2, 16'd2);
        wait_done(lat);
        check("after_abort_add", W'(out), W'(16'd4));

        repeat (3) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
